// File: rtl/msix_irq_collector.sv
// ----------------------------------------------------------------------------
// msix_irq_collector
//   Front-end of the MSI-X manager. Turns raw user interrupt sources into
//   per-vector pending bits (rising-edge or level detection per vector),
//   then gates them with the global enable, the per-vector mask and a
//   per-vector holdoff timer. A round-robin arbiter issues at most one
//   one-cycle pulse per clock on irq[]. Edge events that arrive while their
//   vector is already pending are merged and counted in coalesced_cnt.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   src_irq[N]     raw interrupt sources, synchronous to clk
//   msix_enable    global enable; when low, vectors only accumulate pending
//   vec_mask[N]    per-vector mask; 1 = keep pending, do not issue
//   clear_stats    one-cycle pulse that zeroes coalesced_cnt
//   irq[N]         registered one-hot (or zero) issue pulse
//   pending[N]     registered pending bits (PBA mirror)
//   coalesced_cnt  saturating count of merged edge events
// ----------------------------------------------------------------------------
module msix_irq_collector #(
  parameter int                            C_NUM_IRQ_INPUTS = 4,
  parameter logic [C_NUM_IRQ_INPUTS-1:0]   C_EDGE_MASK      = {C_NUM_IRQ_INPUTS{1'b1}},
  parameter int                            C_HOLDOFF_CYCLES = 8,
  parameter int                            C_CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [C_NUM_IRQ_INPUTS-1:0] src_irq,
  input  logic                        msix_enable,
  input  logic [C_NUM_IRQ_INPUTS-1:0] vec_mask,
  input  logic                        clear_stats,
  output logic [C_NUM_IRQ_INPUTS-1:0] irq,
  output logic [C_NUM_IRQ_INPUTS-1:0] pending,
  output logic [C_CNT_WIDTH-1:0]      coalesced_cnt
);

  localparam int N      = C_NUM_IRQ_INPUTS;
  // A zero holdoff would give a zero-width counter; keep one bit that never loads non-zero.
  localparam int HW_RAW = $clog2(C_HOLDOFF_CYCLES + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;
  localparam int PW     = (N > 1) ? $clog2(N) : 1;

  localparam logic [HW-1:0]          HOLDOFF_LOAD = HW'(C_HOLDOFF_CYCLES);
  localparam logic [PW-1:0]          RR_INIT      = PW'(N - 1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX      = {C_CNT_WIDTH{1'b1}};

  // One-hot decode of a vector index.
  function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Saturating add of a small increment onto the merge counter.
  function automatic logic [C_CNT_WIDTH-1:0] sat_add(input logic [C_CNT_WIDTH-1:0] a,
                                                     input logic [C_CNT_WIDTH:0]   b);
    logic [C_CNT_WIDTH:0] sum;
    sum = {1'b0, a} + b;
    if (sum[C_CNT_WIDTH]) begin
      return CNT_MAX;
    end else begin
      return sum[C_CNT_WIDTH-1:0];
    end
  endfunction

  // Registered state
  logic [N-1:0]           src_q,     src_d;
  logic [N-1:0]           pending_q, pending_d;
  logic [N-1:0]           irq_q,     irq_d;
  logic [PW-1:0]          rr_ptr_q,  rr_ptr_d;
  logic [C_CNT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [N-1:0][HW-1:0]   holdoff_q, holdoff_d;

  // Combinational helpers
  logic [N-1:0]           edge_evt;
  logic [N-1:0]           level_evt;
  logic [N-1:0]           evt;
  logic [N-1:0]           eligible;
  logic                   grant_valid;
  logic [PW-1:0]          grant_idx;
  logic [N-1:0]           issue_vec;
  logic [N-1:0]           merge_vec;
  logic [C_CNT_WIDTH:0]   merge_cnt;
  int                     scan_idx;

  // src_q is cleared by reset, so a source already high at release looks like a rising edge.
  assign edge_evt  = src_irq & ~src_q & C_EDGE_MASK;
  assign level_evt = src_irq & ~C_EDGE_MASK;
  assign evt       = edge_evt | level_evt;

  // Per-vector eligibility for arbitration this cycle.
  always_comb begin
    eligible = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      eligible[i] = pending_q[i] & ~vec_mask[i] & (holdoff_q[i] == {HW{1'b0}}) & msix_enable;
    end
  end

  // Round-robin arbiter: first eligible vector strictly after rr_ptr, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {PW{1'b0}};
    scan_idx    = 0;
    for (int off = 1; off <= N; off++) begin
      scan_idx = (int'(rr_ptr_q) + off) % N;
      if (!grant_valid && eligible[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(scan_idx);
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Next-state for pending, issue pulse, pointer, holdoff timers and merge counter.
  always_comb begin
    src_d     = src_irq;
    issue_vec = grant_valid ? onehot(grant_idx) : {N{1'b0}};
    irq_d     = issue_vec;
    rr_ptr_d  = grant_valid ? grant_idx : rr_ptr_q;
    // A new event in the issuing cycle re-arms the bit, so the event is not lost.
    pending_d = (pending_q & ~issue_vec) | evt;

    holdoff_d = holdoff_q;
    for (int i = 0; i < N; i++) begin
      if (issue_vec[i]) begin
        holdoff_d[i] = HOLDOFF_LOAD;
      end else if (holdoff_q[i] != {HW{1'b0}}) begin
        holdoff_d[i] = holdoff_q[i] - HW'(1);
      end else begin
        holdoff_d[i] = holdoff_q[i];
      end
    end

    // Only edge events landing on an already-pending, not-issuing vector are merges.
    merge_vec = edge_evt & pending_q & ~issue_vec;
    merge_cnt = {(C_CNT_WIDTH+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      merge_cnt = merge_cnt + {{C_CNT_WIDTH{1'b0}}, merge_vec[i]};
    end

    if (clear_stats) begin
      cnt_d = {C_CNT_WIDTH{1'b0}};
    end else begin
      cnt_d = sat_add(cnt_q, merge_cnt);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= {N{1'b0}};
      pending_q <= {N{1'b0}};
      irq_q     <= {N{1'b0}};
      rr_ptr_q  <= RR_INIT;
      cnt_q     <= {C_CNT_WIDTH{1'b0}};
      holdoff_q <= {(N*HW){1'b0}};
    end else begin
      src_q     <= src_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign irq           = irq_q;
  assign pending       = pending_q;
  assign coalesced_cnt = cnt_q;

endmodule

// File: tb/tb_msix_irq_collector.sv
// ----------------------------------------------------------------------------
// tb_msix_irq_collector
//   Self-checking bench for msix_irq_collector (N=4, edge mask 0111, holdoff 8).
//   A behavioural reference model tracks pending bits, the time of each
//   vector's last issue and the round-robin pointer; every cycle the DUT
//   outputs are compared against it. Directed table rows and hand-written
//   sequences add fixed expectations for the multi-cycle corner cases, and
//   a randomized phase exercises mixed traffic.
// ----------------------------------------------------------------------------
module tb_msix_irq_collector;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  src_irq = 4'b0000;
  logic          msix_enable = 1'b0;
  logic [N-1:0]  vec_mask = 4'b0000;
  logic          clear_stats = 1'b0;
  logic [N-1:0]  irq;
  logic [N-1:0]  pending;
  logic [CW-1:0] coalesced_cnt;

  msix_irq_collector #(
    .C_NUM_IRQ_INPUTS (N),
    .C_EDGE_MASK      (4'b0111),
    .C_HOLDOFF_CYCLES (H),
    .C_CNT_WIDTH      (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_irq       (src_irq),
    .msix_enable   (msix_enable),
    .vec_mask      (vec_mask),
    .clear_stats   (clear_stats),
    .irq           (irq),
    .pending       (pending),
    .coalesced_cnt (coalesced_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0] edge_mask = 4'b0111;
  logic [N-1:0] m_src_q, m_pend, m_irq;
  int           m_last[N];
  int           m_rr, m_cnt, m_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_src_q = 4'b0000;
    m_pend  = 4'b0000;
    m_irq   = 4'b0000;
    m_rr    = N - 1;
    m_cnt   = 0;
    for (int i = 0; i < N; i++) m_last[i] = -1000000;
  endfunction

  // One clock edge of the reference behaviour, using the current inputs.
  function automatic void model_step();
    logic [N-1:0] ev;
    int g, inc, k;
    g   = -1;
    inc = 0;
    for (int i = 0; i < N; i++)
      ev[i] = edge_mask[i] ? (src_irq[i] & ~m_src_q[i]) : src_irq[i];
    for (int off = 1; off <= N; off++) begin
      k = (m_rr + off) % N;
      if (g < 0 && m_pend[k] && !vec_mask[k] && msix_enable && (m_t - m_last[k] > H)) g = k;
    end
    for (int i = 0; i < N; i++)
      if (edge_mask[i] && ev[i] && m_pend[i] && i != g) inc++;
    m_irq = 4'b0000;
    if (g >= 0) begin
      m_irq[g]  = 1'b1;
      m_pend[g] = 1'b0;
      m_last[g] = m_t;
      m_rr      = g;
    end
    m_pend = m_pend | ev;
    if (clear_stats) m_cnt = 0;
    else m_cnt = (m_cnt + inc > 65535) ? 65535 : m_cnt + inc;
    m_src_q = src_irq;
  endfunction

  // Advance one clock, update the model, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    m_t++;
    @(negedge clk);
    check("irq", irq, m_irq);
    check("pending", pending, m_pend);
    check("coalesced_cnt", coalesced_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    src_irq = 4'b0000;
    #1;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
  endtask

  task automatic idle(input int n);
    src_irq = 4'b0000;
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic          do_rst;
    logic [N-1:0]  src;
    logic [N-1:0]  mask;
    logic          en;
    logic [N-1:0]  exp_irq;
    logic [N-1:0]  exp_pend;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t tbl[11];
  int   t_first, t_second, pulses, last_t;
  logic bad_period;

  initial begin
    // Fresh reset + 0101 pulse: vectors 0 then 2 issue on consecutive cycles.
    tbl[0]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0101, 16'd0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0100, 16'd0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0000, 16'd0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'd0};
    // Disabled accumulation of 1111, then enable drains in round-robin order.
    tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111, 16'd0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 16'd0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b1110, 16'd0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b1100, 16'd0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b1000, 16'd0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0000, 16'd0};
    tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 16'd0};

    m_t = 0;
    model_reset();
    #2;
    check("reset_irq", irq, 4'b0000);
    check("reset_pending", pending, 4'b0000);
    check("reset_cnt", coalesced_cnt, 16'd0);
    @(negedge clk);

    // ---- table-driven rows ----
    for (int r = 0; r < 11; r++) begin
      if (tbl[r].do_rst) begin
        msix_enable = tbl[r].en;
        vec_mask    = tbl[r].mask;
        do_reset();
      end
      src_irq     = tbl[r].src;
      vec_mask    = tbl[r].mask;
      msix_enable = tbl[r].en;
      cycle();
      check($sformatf("tbl%0d_irq", r), irq, tbl[r].exp_irq);
      check($sformatf("tbl%0d_pend", r), pending, tbl[r].exp_pend);
      check($sformatf("tbl%0d_cnt", r), coalesced_cnt, tbl[r].exp_cnt);
    end

    // ---- holdoff spacing and coalescing on vector 0 ----
    msix_enable = 1'b1;
    vec_mask    = 4'b0000;
    idle(12);
    t_first  = -1;
    t_second = -1;
    for (int t = 0; t < 25; t++) begin
      src_irq = (t == 0 || t == 3 || t == 5) ? 4'b0001 : 4'b0000;
      cycle();
      if (irq[0]) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
        else t_second = t_second;
      end
      if (t == 4) check("t2_cnt_before_merge", coalesced_cnt, 16'd0);
    end
    check("t2_first_latency", t_first, 1);
    check("t2_holdoff_interval", t_second - t_first, 9);
    check("t2_cnt_after_merge", coalesced_cnt, 16'd1);
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    check("t2_cnt_cleared", coalesced_cnt, 16'd0);

    // ---- masked vector accumulates, unmask releases one pulse ----
    idle(12);
    vec_mask = 4'b0010;
    src_irq  = 4'b0010;
    cycle();
    src_irq = 4'b0000;
    pulses  = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (irq != 4'b0000) pulses++;
    end
    check("t3_masked_no_irq", pulses, 0);
    check("t3_masked_pending", pending, 4'b0010);
    vec_mask = 4'b0000;
    pulses   = 0;
    for (int t = 0; t < 6; t++) begin
      cycle();
      if (irq == 4'b0010) pulses++;
    end
    check("t3_unmask_one_pulse", pulses, 1);
    check("t3_pending_clear", pending, 4'b0000);

    // ---- level vector 3 held high: periodic pulses, no merges ----
    idle(12);
    pulses     = 0;
    last_t     = -1;
    bad_period = 1'b0;
    for (int t = 0; t < 70; t++) begin
      src_irq = (t < 40) ? 4'b1000 : 4'b0000;
      cycle();
      if (irq[3]) begin
        if (last_t >= 0 && (t - last_t) != 9) bad_period = 1'b1;
        else bad_period = bad_period;
        last_t = t;
        pulses++;
      end
    end
    check("t5_period_9", bad_period, 1'b0);
    check("t5_pulse_count", pulses, 6);
    check("t5_last_pulse", last_t, 46);
    check("t5_cnt_zero", coalesced_cnt, 16'd0);

    // ---- asynchronous reset with pending and active holdoff ----
    idle(12);
    src_irq = 4'b1010;
    cycle();
    src_irq = 4'b1000;
    cycle();
    cycle();
    cycle();
    src_irq = 4'b1010;
    cycle();
    src_irq = 4'b1000;
    cycle();
    check("t6_pending_before_reset", pending, 4'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_async_irq", irq, 4'b0000);
    check("t6_async_pending", pending, 4'b0000);
    check("t6_async_cnt", coalesced_cnt, 16'd0);
    @(negedge clk);
    cycle();
    cycle();
    rst_n  = 1'b1;
    pulses = 0;
    for (int t = 0; t < 5; t++) begin
      cycle();
      if (irq[3]) pulses++;
    end
    check("t6_refire_after_reset", pulses, 1);

    // ---- randomized traffic against the model ----
    for (int t = 0; t < 1500; t++) begin
      src_irq     = 4'($urandom_range(0, 15));
      vec_mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      msix_enable = ($urandom_range(0, 7) != 0);
      clear_stats = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clear_stats = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
